multicycle_ctrl: RTL

Multi-cycle sequencer for the MIPS-style datapath. It owns the PC and the instruction register. It fetches over a req/ack instruction port and decodes the same 32-bit format used by the single-cycle decoder. It steps the shared ALU, register file and data memory through FETCH/DECODE/EXEC/MEM/WB. It drives ALUOpsel, we1/we2 and sel1/sel2 equivalents, one instruction at a time.

---
 rtl/multicycle_ctrl.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Multi-cycle sequencer for the MIPS-style datapath. It owns the PC and the
//   instruction register. It fetches over a req/ack instruction port and
//   steps the shared ALU, register file and data memory through
//   FETCH/DECODE/EXEC/MEM/WB, one instruction at a time.
//
// Ports:
//   clk, rst_n              clock (rising edge), synchronous active-low reset
//   imem_addr/req/ack/rdata instruction fetch handshake (imem_addr = PC)
//   dmem_req/ack            data access handshake, we2 qualifies a store
//   alu_zero                ALU zero flag, used to resolve BEQ
//   ALUOpsel, sel1, sel2    datapath controls, decoded from the IR
//   rs/rt/rd_addr, imm      instruction fields, decoded from the IR
//   we1                     register file write strobe (one cycle in WB)
//   halted, illegal, bus_err status (illegal is sticky)
//   instret                 retired-instruction counter
//
// Optional feature macro: MULTICYCLE_CTRL_PERF_EN
//   defined   -> instret counts retired instructions (wraps at 0xFFFF)
//   undefined -> instret is tied to zero and no counter flops exist
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}},
    parameter int              MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    input  logic            dmem_ack,
    input  logic            alu_zero,
    output logic [3:0]      ALUOpsel,
    output logic [5:0]      rs_addr,
    output logic [5:0]      rt_addr,
    output logic [5:0]      rd_addr,
    output logic [14:0]     imm,
    output logic            we1,
    output logic            we2,
    output logic            sel1,
    output logic            sel2,
    output logic            halted,
    output logic            illegal,
    output logic            bus_err,
    output logic [15:0]     instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALTED = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    localparam logic [PC_W-1:0] PC_ONE    = {{(PC_W-1){1'b0}}, 1'b1};
    // Last wait count at which a missing ack still leaves the request alive;
    // a request is therefore outstanding for at most MAX_WAIT cycles.
    localparam logic [3:0]      WAIT_LAST = 4'(MAX_WAIT - 1);

    state_t          state_r, state_s;
    logic [PC_W-1:0] pc_r, pc_s;
    logic [31:0]     ir_r, ir_s;
    logic [3:0]      wait_r, wait_s;
    logic            illegal_r, illegal_s;
    logic            imem_req_s, dmem_req_s, we1_s, we2_s;

    logic [3:0]      opcode_s;
    logic            is_rtype_s, is_addi_s, is_lw_s, is_sw_s, is_beq_s, is_halt_s;
    logic            is_legal_s;
    logic [PC_W-1:0] pc_inc_s, pc_br_s;

    assign opcode_s   = ir_r[31:28];
    assign is_rtype_s = ~opcode_s[3];
    assign is_addi_s  = (opcode_s == 4'b1000);
    assign is_lw_s    = (opcode_s == 4'b1001);
    assign is_sw_s    = (opcode_s == 4'b1010);
    assign is_beq_s   = (opcode_s == 4'b1011);
    assign is_halt_s  = (opcode_s == 4'b1111);
    assign is_legal_s = is_rtype_s | is_addi_s | is_lw_s | is_sw_s | is_beq_s | is_halt_s;

    assign pc_inc_s = pc_r + PC_ONE;
    assign pc_br_s  = pc_inc_s + {{(PC_W-15){ir_r[14]}}, ir_r[14:0]};

    assign rs_addr   = ir_r[27:22];
    assign rt_addr   = ir_r[21:16];
    assign rd_addr   = is_rtype_s ? ir_r[15:10] : ir_r[21:16];
    assign imm       = ir_r[14:0];
    assign imem_addr = pc_r;

    // Datapath control decode from the instruction register.
    always_comb begin
        ALUOpsel = 4'b0000;
        sel1     = is_lw_s;
        sel2     = is_addi_s | is_lw_s | is_sw_s;
        if (is_rtype_s) begin
            ALUOpsel = {1'b0, opcode_s[2:0]};
        end else if (is_beq_s) begin
            ALUOpsel = 4'b0001;
        end else begin
            ALUOpsel = 4'b0000;
        end
    end

    // Next-state, PC/IR update and strobe generation.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        ir_s       = ir_r;
        wait_s     = wait_r;
        illegal_s  = illegal_r;
        imem_req_s = 1'b0;
        dmem_req_s = 1'b0;
        we1_s      = 1'b0;
        we2_s      = 1'b0;
        case (state_r)
            S_FETCH: begin
                imem_req_s = 1'b1;
                if (imem_ack) begin
                    ir_s    = imem_rdata;
                    state_s = S_DECODE;
                end else if (wait_r == WAIT_LAST) begin
                    state_s = S_ERROR;
                end else begin
                    wait_s = wait_r + 4'd1;
                end
            end
            S_DECODE: begin
                if (is_halt_s) begin
                    state_s = S_HALTED;
                end else if (!is_legal_s) begin
                    illegal_s = 1'b1;
                    pc_s      = pc_inc_s;
                    state_s   = S_FETCH;
                end else begin
                    state_s = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_beq_s) begin
                    pc_s    = alu_zero ? pc_br_s : pc_inc_s;
                    state_s = S_FETCH;
                end else if (is_lw_s || is_sw_s) begin
                    state_s = S_MEM;
                end else begin
                    state_s = S_WB;
                end
            end
            S_MEM: begin
                dmem_req_s = 1'b1;
                we2_s      = is_sw_s;
                if (dmem_ack) begin
                    if (is_lw_s) begin
                        state_s = S_WB;
                    end else begin
                        pc_s    = pc_inc_s;
                        state_s = S_FETCH;
                    end
                end else if (wait_r == WAIT_LAST) begin
                    state_s = S_ERROR;
                end else begin
                    wait_s = wait_r + 4'd1;
                end
            end
            S_WB: begin
                we1_s   = 1'b1;
                pc_s    = pc_inc_s;
                state_s = S_FETCH;
            end
            S_HALTED: begin
                state_s = S_HALTED;
            end
            S_ERROR: begin
                state_s = S_ERROR;
            end
            default: begin
                state_s = S_ERROR;
            end
        endcase
        if (state_s != state_r) begin
            wait_s = 4'd0;
        end else begin
            wait_s = wait_s;
        end
    end

    // Strobes are forced low while reset is held so an aborted access drops
    // its request immediately.
    assign imem_req = imem_req_s & rst_n;
    assign dmem_req = dmem_req_s & rst_n;
    assign we1      = we1_s & rst_n;
    assign we2      = we2_s & rst_n;
    assign halted   = (state_r == S_HALTED);
    assign bus_err  = (state_r == S_ERROR);
    assign illegal  = illegal_r;

    // Sequencer state, PC, IR, wait counter and sticky illegal flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= S_FETCH;
            pc_r      <= RESET_PC;
            ir_r      <= 32'd0;
            wait_r    <= 4'd0;
            illegal_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            pc_r      <= pc_s;
            ir_r      <= ir_s;
            wait_r    <= wait_s;
            illegal_r <= illegal_s;
        end
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic        retire_s;
    logic [15:0] instret_r;

    assign retire_s = ((state_r == S_EXEC) && is_beq_s) ||
                      ((state_r == S_MEM) && is_sw_s && dmem_ack) ||
                      (state_r == S_WB);

    // Retired-instruction counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instret_r <= 16'd0;
        end else if (retire_s) begin
            instret_r <= instret_r + 16'd1;
        end else begin
            instret_r <= instret_r;
        end
    end

    assign instret = instret_r;
`else
    assign instret = 16'd0;
`endif

endmodule
